rvv_backend_dispatch_bypass_stage: RTL and testbench

- Registered, flow-controlled operand bypass stage between dispatch and the RS/PU issue path.
- Captures a uop's N VRF-read operands plus its per-operand ROB RAW-hit vectors.
- While held, merges ROB write data byte-by-byte using live ROB state, with age-ordered priority relative to the ROB head.
- Releases the uop only when every hit entry has produced data. Folds retiring entries into the held base data so VRF writeback is never missed.

---
 rtl/rvv_backend_dispatch_bypass_stage.sv | 169 ++++++++++++++++
 tb/tb_rvv_backend_dispatch_bypass_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rvv_backend_dispatch_bypass_stage.sv
// Registered operand bypass stage between dispatch and RS/PU issue: holds one uop and merges live ROB results into it.
// Build option: define RVV_BYPASS_AGNOSTIC_FILL_EN to fill selected mask/tail-agnostic bytes with 8'hFF.
module rvv_backend_dispatch_bypass_stage #(
    parameter int ROB_DEPTH = 8,
    parameter int VLENB     = 16,
    parameter int NUM_OPN   = 4,
    parameter int TAG_W     = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_OPN*VLENB*8-1:0]      in_vrf_data,
    input  logic [NUM_OPN*ROB_DEPTH-1:0]    in_hit,
    input  logic [TAG_W-1:0]                in_tag,
    input  logic [$clog2(ROB_DEPTH)-1:0]    rob_head,
    input  logic [ROB_DEPTH-1:0]            rob_done,
    input  logic [ROB_DEPTH-1:0]            rob_retire,
    input  logic [ROB_DEPTH*VLENB*2-1:0]    rob_byte_type,
    input  logic [ROB_DEPTH-1:0]            rob_inactive_one,
    input  logic [ROB_DEPTH-1:0]            rob_tail_one,
    input  logic [ROB_DEPTH*VLENB*8-1:0]    rob_wdata,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_OPN*VLENB*8-1:0]      out_opn,
    output logic [TAG_W-1:0]                out_tag
);

    localparam int IDX_W = $clog2(ROB_DEPTH);
    localparam int OPN_W = NUM_OPN*VLENB*8;
    localparam int HIT_W = NUM_OPN*ROB_DEPTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_VALID
    } state_t;

    state_t             state;
    logic [OPN_W-1:0]   base_q;
    logic [HIT_W-1:0]   hit_q;
    logic [TAG_W-1:0]   tag_q;

    logic               capture;
    logic               all_done_in;
    logic               all_done_held;
    logic [OPN_W-1:0]   fold_base;
    logic [HIT_W-1:0]   fold_hit;
    logic [OPN_W-1:0]   base_d;
    logic [HIT_W-1:0]   hit_d;

    // Returns {select, agnostic_fill} for one ROB byte given its type and agnostic enables.
    function automatic logic [1:0] byte_mode(input logic [1:0] btype,
                                             input logic       inactive_one,
                                             input logic       tail_one);
`ifdef RVV_BYPASS_AGNOSTIC_FILL_EN
        case (btype)
            2'd0:    byte_mode = 2'b10;
            2'd1:    byte_mode = {inactive_one, 1'b1};
            2'd2:    byte_mode = {tail_one, 1'b1};
            default: byte_mode = 2'b00;
        endcase
`else
        // Agnostic bytes are left undisturbed, so only BODY_ACTIVE data is ever taken.
        byte_mode = {btype == 2'd0 && !inactive_one && !tail_one ? 1'b1 : btype == 2'd0, 1'b0};
`endif
    endfunction

    assign in_ready  = (state == S_IDLE) | (out_valid & out_ready);
    assign capture   = in_valid & in_ready & ~flush;
    assign out_tag   = tag_q;

    assign all_done_in   = ~|(in_hit & {NUM_OPN{~rob_done}});
    assign all_done_held = ~|(hit_q & {NUM_OPN{~rob_done}});

    // Walk entries oldest to youngest so a younger selecting entry overwrites an older one.
    always_comb begin
        logic [IDX_W-1:0] idx;
        logic [1:0]       mode;
        // NOTE: every combinational output gets a default first; a path that skips assignment would infer a latch.
        out_opn = base_q;
        idx     = '0;
        mode    = '0;
        for (int a = 0; a < ROB_DEPTH; a++) begin
            idx = rob_head + IDX_W'(a);
            for (int k = 0; k < NUM_OPN; k++) begin
                for (int j = 0; j < VLENB; j++) begin
                    mode = byte_mode(rob_byte_type[(int'(idx)*VLENB + j)*2 +: 2],
                                     rob_inactive_one[idx], rob_tail_one[idx]);
                    if (hit_q[k*ROB_DEPTH + int'(idx)] && rob_done[idx] && mode[1])
                        out_opn[(k*VLENB + j)*8 +: 8] = mode[0] ? 8'hFF
                                                      : rob_wdata[(int'(idx)*VLENB + j)*8 +: 8];
                end
            end
        end
    end

    // A capture folds retiring entries into the incoming data, since those entries vanish next cycle.
    assign fold_base = capture ? in_vrf_data : base_q;
    assign fold_hit  = capture ? in_hit      : hit_q;

    always_comb begin
        logic [1:0] mode;
        base_d = fold_base;
        hit_d  = fold_hit;
        mode   = '0;
        for (int i = 0; i < ROB_DEPTH; i++) begin
            if (rob_retire[i] && rob_done[i]) begin
                for (int k = 0; k < NUM_OPN; k++) begin
                    if (fold_hit[k*ROB_DEPTH + i]) begin
                        for (int j = 0; j < VLENB; j++) begin
                            mode = byte_mode(rob_byte_type[(i*VLENB + j)*2 +: 2],
                                             rob_inactive_one[i], rob_tail_one[i]);
                            if (mode[1])
                                base_d[(k*VLENB + j)*8 +: 8] = mode[0] ? 8'hFF
                                                             : rob_wdata[(i*VLENB + j)*8 +: 8];
                        end
                        hit_d[k*ROB_DEPTH + i] = 1'b0;
                    end
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            base_q    <= '0;
            hit_q     <= '0;
            tag_q     <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
        end else if (capture) begin
            base_q    <= base_d;
            hit_q     <= hit_d;
            tag_q     <= in_tag;
            state     <= all_done_in ? S_VALID : S_WAIT;
            out_valid <= all_done_in;
        end else begin
            if (state != S_IDLE) begin
                base_q <= base_d;
                hit_q  <= hit_d;
            end
            case (state)
                S_WAIT: begin
                    if (all_done_held) begin
                        state     <= S_VALID;
                        out_valid <= 1'b1;
                    end
                end
                S_VALID: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rvv_backend_dispatch_bypass_stage.sv
// Directed self-checking bench for rvv_backend_dispatch_bypass_stage (default parameters).
module tb_rvv_backend_dispatch_bypass_stage;

    localparam int RD  = 8;
    localparam int VB  = 16;
    localparam int NO  = 4;
    localparam int TW  = 32;
    localparam int OPB = VB*8;
    localparam int OW  = NO*OPB;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [OW-1:0]     in_vrf_data = '0;
    logic [NO*RD-1:0]  in_hit = '0;
    logic [TW-1:0]     in_tag = '0;
    logic [2:0]        rob_head = '0;
    logic [RD-1:0]     rob_done = '0;
    logic [RD-1:0]     rob_retire = '0;
    logic [RD*VB*2-1:0] rob_byte_type = '0;
    logic [RD-1:0]     rob_inactive_one = '0;
    logic [RD-1:0]     rob_tail_one = '0;
    logic [RD*VB*8-1:0] rob_wdata = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [OW-1:0]     out_opn;
    logic [TW-1:0]     out_tag;

    int n_vec = 0;
    int n_err = 0;

    rvv_backend_dispatch_bypass_stage #(
        .ROB_DEPTH(RD), .VLENB(VB), .NUM_OPN(NO), .TAG_W(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_vrf_data(in_vrf_data), .in_hit(in_hit), .in_tag(in_tag),
        .rob_head(rob_head), .rob_done(rob_done), .rob_retire(rob_retire),
        .rob_byte_type(rob_byte_type), .rob_inactive_one(rob_inactive_one),
        .rob_tail_one(rob_tail_one), .rob_wdata(rob_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opn(out_opn), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && ((rob_retire & ~rob_done) != '0))
            $error("retire of an entry whose data is not done");
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [OPB-1:0] got, input logic [OPB-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OPB-1:0] rep(input logic [7:0] b);
        return {VB{b}};
    endfunction

    task automatic set_entry(input int i, input logic [7:0] b);
        for (int j = 0; j < VB; j++) rob_wdata[(i*VB + j)*8 +: 8] = b;
    endtask

    function automatic logic [OPB-1:0] opn(input int k);
        return out_opn[k*OPB +: OPB];
    endfunction

    logic [OPB-1:0] exp_vd;

    initial begin
        in_vrf_data = {rep(8'h33), rep(8'h22), rep(8'h11), rep(8'h01)};
        repeat (2) tick();
        check("rst_out_valid", OPB'(out_valid), OPB'(1'b0));
        check("rst_in_ready", OPB'(in_ready), OPB'(1'b1));
        @(negedge clk) rst_n = 1'b1;
        tick();

        // no hits: one-cycle latency, then back-to-back with release
        in_tag = 32'h1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        check("nohit_valid", OPB'(out_valid), OPB'(1'b1));
        check("nohit_vs2", opn(1), rep(8'h11));
        check("nohit_tag", OPB'(out_tag), OPB'(32'h1));
        check("b2b_in_ready", OPB'(in_ready), OPB'(1'b1));
        in_vrf_data[OPB +: OPB] = rep(8'h44); in_tag = 32'h2;
        tick();
        check("b2b_valid", OPB'(out_valid), OPB'(1'b1));
        check("b2b_vs2", opn(1), rep(8'h44));
        check("b2b_tag", OPB'(out_tag), OPB'(32'h2));
        in_valid = 1'b0;
        tick();
        check("drain_valid", OPB'(out_valid), OPB'(1'b0));

        // vs1 waits on entry 3
        in_hit = '0; in_hit[0*RD + 3] = 1'b1; set_entry(3, 8'hA5);
        rob_done = '0; in_tag = 32'h3; out_ready = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_hit = '0;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("wait_valid_%0d", c), OPB'(out_valid), OPB'(1'b0));
            if (c < 3) tick();
        end
        check("wait_in_ready", OPB'(in_ready), OPB'(1'b0));
        rob_done[3] = 1'b1;
        tick();
        check("wait_done_valid", OPB'(out_valid), OPB'(1'b1));
        check("wait_vs1", opn(0), rep(8'hA5));
        check("wait_vs2_base", opn(1), rep(8'h44));
        out_ready = 1'b1;
        tick();
        rob_done = '0;

        // age priority across the ROB wrap
        rob_head = 3'd6; in_hit = '0; in_hit[1*RD + 7] = 1'b1; in_hit[1*RD + 1] = 1'b1;
        set_entry(7, 8'h77); set_entry(1, 8'h1E); rob_done = 8'b1000_0010;
        out_ready = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_hit = '0;
        check("age_valid", OPB'(out_valid), OPB'(1'b1));
        check("age_head6_vs2", opn(1), rep(8'h1E));
        rob_head = 3'd0;
        #1;
        check("age_head0_vs2", opn(1), rep(8'h77));
        check("age_vs1_base", opn(0), rep(8'h01));
        out_ready = 1'b1;
        tick();
        rob_done = '0;

        // retire fold of a TAIL byte into vd
        in_hit = '0; in_hit[2*RD + 2] = 1'b1; set_entry(2, 8'hC3);
        rob_byte_type[(2*VB + 0)*2 +: 2] = 2'd2; rob_tail_one[2] = 1'b1; rob_done[2] = 1'b1;
        out_ready = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_hit = '0;
        exp_vd = rep(8'hC3);
`ifdef RVV_BYPASS_AGNOSTIC_FILL_EN
        exp_vd[7:0] = 8'hFF;
`else
        exp_vd[7:0] = 8'h22;
`endif
        check("tail_merge_vd", opn(2), exp_vd);
        rob_retire[2] = 1'b1;
        tick();
        rob_retire = '0; set_entry(2, 8'h5A);
        #1;
        check("fold_vd", opn(2), exp_vd);
        check("fold_valid", OPB'(out_valid), OPB'(1'b1));
        out_ready = 1'b1;
        tick();
        rob_byte_type = '0; rob_tail_one = '0; rob_done = '0;

        // flush overrides hold and suppresses capture
        out_ready = 1'b0; in_valid = 1'b1;
        tick();
        check("pre_flush_valid", OPB'(out_valid), OPB'(1'b1));
        flush = 1'b1;
        tick();
        check("flush_valid", OPB'(out_valid), OPB'(1'b0));
        check("flush_in_ready", OPB'(in_ready), OPB'(1'b1));
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check("flush_no_capture", OPB'(out_valid), OPB'(1'b0));

        // async reset while waiting discards the uop
        in_hit = '0; in_hit[0*RD + 4] = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_hit = '0;
        check("rstw_in_ready_pre", OPB'(in_ready), OPB'(1'b0));
        #2 rst_n = 1'b0;
        #1;
        check("rstw_in_ready", OPB'(in_ready), OPB'(1'b1));
        check("rstw_valid", OPB'(out_valid), OPB'(1'b0));
        rob_done[4] = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("rstw_discard", OPB'(out_valid), OPB'(1'b0));
        rob_done = '0;

        // async reset in VALID drops out_valid without a clock edge
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("rstv_pre", OPB'(out_valid), OPB'(1'b1));
        #2 rst_n = 1'b0;
        #1;
        check("rstv_valid", OPB'(out_valid), OPB'(1'b0));
        @(negedge clk) rst_n = 1'b1;
        tick();

        // type-3 bytes are never selected
        in_hit = '0; in_hit[3*RD + 5] = 1'b1; rob_done[5] = 1'b1; set_entry(5, 8'hEE);
        for (int j = 0; j < VB; j++) rob_byte_type[(5*VB + j)*2 +: 2] = 2'd3;
        rob_inactive_one = '1; rob_tail_one = '1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_hit = '0;
        check("t3_valid", OPB'(out_valid), OPB'(1'b1));
        check("t3_v0", opn(3), rep(8'h33));
        out_ready = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
